// File: rtl/urand_pair_gen.sv
// urand_pair_gen
// Uniform random-pair source for the Box-Muller stage. A 64-bit xorshift
// generator is stepped twice per pair. Each 53-bit draw is turned into an
// exact IEEE-754 double in (0,1), and the pair is presented on o_u1/o_u2
// with a one-cycle o_pushout strobe. The downstream stage has no
// backpressure, so the output rate is paced by a fixed idle gap of GAP
// cycles after each push.
//
// Parameters:
//   SEED_INIT   generator state loaded at reset (zero is replaced by a
//               nonzero constant)
//   GAP         extra idle cycles after each push, 0..15
// Ports:
//   i_clk       clock, rising-edge active
//   i_rst_n     asynchronous active-low reset
//   i_enable    run continuously while 1; sampled in IDLE and at end of WAIT
//   i_seed_load load i_seed into the generator; aborts any in-flight pair
//   i_seed      new generator state (zero is replaced by a nonzero constant)
//   o_pushout   one-cycle strobe per pair
//   o_u1        first draw as an IEEE double in (0,1)
//   o_u2        second draw as an IEEE double in (0,1)
//   o_pair_cnt  number of pairs pushed, wraps at 2^32
module urand_pair_gen #(
  parameter logic [63:0] SEED_INIT = 64'h0123456789ABCDEF,
  parameter int unsigned GAP       = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_seed_load,
  input  logic [63:0] i_seed,
  output logic        o_pushout,
  output logic [63:0] o_u1,
  output logic [63:0] o_u2,
  output logic [31:0] o_pair_cnt
);

  // The all-zero state is a fixed point of xorshift, so it is never held.
  localparam logic [63:0] SEED_ZERO_SUB = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SEED_RESET    = (SEED_INIT == 64'd0) ? SEED_ZERO_SUB : SEED_INIT;
  localparam logic [3:0]  GAP_LOAD      = 4'(GAP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP1 = 3'd1,
    ST_STEP2 = 3'd2,
    ST_CONV  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // One xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Exact conversion of k * 2^-53 to an IEEE double. k is never zero here,
  // so the leading-one position p is always valid and the value is normal.
  function automatic logic [63:0] k_to_double(input logic [52:0] k);
    logic [5:0]  p;
    logic [52:0] norm;
    logic [10:0] expo;
    p = 6'd0;
    for (int i = 0; i < 53; i++) begin
      p = k[i] ? 6'(i) : p;
    end
    norm = k << (6'd52 - p);
    expo = 11'd970 + {5'd0, p};
    return {1'b0, expo, norm[51:0]};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_x;
  logic [52:0] r_k1;
  logic [52:0] r_k2;
  logic [3:0]  r_gap;

  logic [63:0] w_x_next;
  logic [52:0] w_k_next;
  logic [63:0] w_u1_conv;
  logic [63:0] w_u2_conv;
  logic        w_step;
  logic        w_cap_k1;
  logic        w_cap_k2;
  logic        w_push;
  logic        w_gap_dec;

  assign w_x_next  = xs_step(r_x);
  // A zero draw is replaced by 1 so the output stays strictly above 0.
  assign w_k_next  = (w_x_next[63:11] == 53'd0) ? 53'd1 : w_x_next[63:11];
  assign w_u1_conv = k_to_double(r_k1);
  assign w_u2_conv = k_to_double(r_k2);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a seed load abandons whatever the FSM was doing.
  always_comb begin
    w_next_state = r_state;
    if (i_seed_load) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = i_enable ? ST_STEP1 : ST_IDLE;
        ST_STEP1: w_next_state = ST_STEP2;
        ST_STEP2: w_next_state = ST_CONV;
        ST_CONV:  w_next_state = ST_WAIT;
        ST_WAIT: begin
          if (r_gap == 4'd0) begin
            w_next_state = i_enable ? ST_STEP1 : ST_IDLE;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // Per-state datapath controls.
  always_comb begin
    w_step    = 1'b0;
    w_cap_k1  = 1'b0;
    w_cap_k2  = 1'b0;
    w_push    = 1'b0;
    w_gap_dec = 1'b0;
    case (r_state)
      ST_STEP1: begin
        w_step   = 1'b1;
        w_cap_k1 = 1'b1;
      end
      ST_STEP2: begin
        w_step   = 1'b1;
        w_cap_k2 = 1'b1;
      end
      ST_CONV:  w_push    = 1'b1;
      ST_WAIT:  w_gap_dec = (r_gap != 4'd0);
      default:  w_push    = 1'b0;
    endcase
  end

  // Generator, draws, gap counter and registered outputs. A seed load only
  // touches the generator and the strobe; the visible pair and count stay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= SEED_RESET;
      r_k1       <= 53'd0;
      r_k2       <= 53'd0;
      r_gap      <= 4'd0;
      o_pushout  <= 1'b0;
      o_u1       <= 64'd0;
      o_u2       <= 64'd0;
      o_pair_cnt <= 32'd0;
    end else if (i_seed_load) begin
      r_x       <= (i_seed == 64'd0) ? SEED_ZERO_SUB : i_seed;
      o_pushout <= 1'b0;
    end else begin
      o_pushout <= w_push;
      if (w_step) begin
        r_x <= w_x_next;
      end else begin
        r_x <= r_x;
      end
      if (w_cap_k1) begin
        r_k1 <= w_k_next;
      end else begin
        r_k1 <= r_k1;
      end
      if (w_cap_k2) begin
        r_k2 <= w_k_next;
      end else begin
        r_k2 <= r_k2;
      end
      if (w_push) begin
        o_u1       <= w_u1_conv;
        o_u2       <= w_u2_conv;
        o_pair_cnt <= o_pair_cnt + 32'd1;
        r_gap      <= GAP_LOAD;
      end else if (w_gap_dec) begin
        r_gap <= r_gap - 4'd1;
      end else begin
        r_gap <= r_gap;
      end
    end
  end

endmodule

// File: doc/urand_pair_gen.md
# urand_pair_gen

Uniform random-pair source that sits directly upstream of the Box-Muller stage (`randist`). It runs a 64-bit xorshift generator, converts two successive 53-bit draws into exact IEEE-754 doubles in the open interval (0,1), and presents them as U1/U2 with a one-cycle `pushout` strobe that feeds `randist`'s `pushin`. `randist` has no backpressure, so this block paces its own output with a programmable gap.

## Interface
- `SEED_INIT`, default 64'h0123456789ABCDEF: generator state loaded at reset.
- `GAP`, default 2: number of extra idle cycles after each push (0..15).
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-low.
- `enable` input, 1 bit: when 1, pairs are generated continuously; when 0, the block returns to IDLE after finishing the current pair.
- `seed_load` input, 1 bit: when 1, loads `seed` into the generator state.
- `seed` input, 64 bits: new generator state.
- `pushout` output, 1 bit: 1 for exactly one cycle per pair.
- `U1` output, 64 bits: IEEE double in (0,1), first draw.
- `U2` output, 64 bits: IEEE double in (0,1), second draw.
- `pair_cnt` output, 32 bits: count of pairs pushed; wraps from 2^32-1 to 0.

## Operation
- **Generator step:** x ^= x<<13; x ^= x>>7; x ^= x<<17. Each step takes one cycle. Draw k = new_x[63:11] (53 bits). If k==0, use k=1 instead.
- **Conversion:** U = k·2^-53, which is exact.
  - p = index of the highest set bit of k (0..52).
  - sign = 0.
  - exponent = 970+p.
  - mantissa = (k << (52-p))[51:0].
- **States:**
  - IDLE: if `enable`=1, go to STEP1.
  - STEP1: step the generator and capture k1; go to STEP2.
  - STEP2: step the generator and capture k2; go to CONV.
  - CONV: register U1=conv(k1) and U2=conv(k2), set `pushout`=1, increment `pair_cnt`, load the gap counter with GAP; go to WAIT.
  - WAIT: set `pushout`=0. If the counter is 0, go to STEP1 when `enable`=1, otherwise to IDLE. If the counter is not 0, decrement it.
- **`enable` while busy:** dropping `enable` mid-pair does not abort the pair. It is sampled only in IDLE and at the end of WAIT.
- **`seed_load`:** has priority in every state. The state becomes `seed`; if `seed`==0, it becomes 64'h9E3779B97F4A7C15 instead, so the generator never holds the zero state. Any in-flight pair is discarded, the FSM goes to IDLE, and `pushout`<=0. U1, U2 and `pair_cnt` are unchanged.
- **Reset** (any time, including mid-pair):
  - generator state = SEED_INIT, or 64'h9E3779B97F4A7C15 if SEED_INIT==0.
  - FSM = IDLE.
  - `pushout`=0, U1=0, U2=0, `pair_cnt`=0.
  - k1, k2 and the gap counter = 0.

## Timing
- All outputs are registered. They change only just after a rising edge, which gives `randist` hold time.
- U1/U2 stay stable from CONV until the next CONV.
- `pushout` is never X after reset.
- **Latency:** `enable`=1 sampled in IDLE at edge t gives `pushout`=1 in the cycle after edge t+3.
- **Pair period:** 4+GAP cycles while `enable` stays 1. With GAP=0 this is one push every 4 cycles. `pushout` is never high on two consecutive cycles.
- **Simultaneous events:**
  - `seed_load` and `enable` both 1: the seed load wins, and the FSM stays in IDLE for that edge.
  - `seed_load` during CONV: no push occurs and `pair_cnt` is unchanged.
- **`pair_cnt` wrap:** 32'hFFFFFFFF plus one push gives 0, with no other side effect.
- **Reset release:** the first generator step happens no earlier than 2 edges after `rst` rises.

## Test plan
- **Reset values:** hold `rst`=0 for 5 cycles → `pushout`=0, U1=U2=0, `pair_cnt`=0. Assert `rst` mid-WAIT → the same values immediately, without waiting for a clock edge.
- **Known seed:** `seed_load` with seed=1, then `enable`=1 → the first push gives U1=64'h3DD0208800000000 (k1=0x81044). U2 matches the bench's xorshift/conversion model. `pushout` goes high exactly 4 edges after `enable` is sampled.
- **Continuous run:** GAP=0, `enable` held high for 1000 pairs:
  - pushes exactly 4 cycles apart;
  - every U1/U2 bit-matches the model, has the sign bit at 0, lies in (0,1), and has exponent in 0x3CA..0x3FE;
  - `pair_cnt`=1000.
- **Conversion corners** via model-selected seeds: k=1 → 64'h3CA0000000000000; k=2^53-1 → 64'h3FEFFFFFFFFFFFFF; k=0 → substituted with k=1 → 64'h3CA0000000000000.
- **Zero seed and seed-load priority:**
  - `seed_load` with seed=0 → the next draws match a model seeded with 64'h9E3779B97F4A7C15.
  - `seed_load` during STEP2 → no push, FSM back in IDLE, `pair_cnt` unchanged.
- **Drive `randist` end to end:** connect `pushout`/U1/U2 to `randist`, run 10000 pairs with GAP=3 → no "No hold time" failures, and every Z from `randist` is within 1e-8 of the reference Box-Muller value.
